// File: rtl/apb_mem_arbiter.sv
// Two-port APB3 arbiter onto one shared memory port: round-robin grant, latched request, watchdog abort.
// Three cycles from PSEL to PREADY with a zero-wait memory; the losing requester is wait-stated until served.
module apb_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK_BASE,
  input  logic              RESET_N,
  input  logic              S0_PSEL,
  input  logic              S0_PENABLE,
  input  logic              S0_PWRITE,
  input  logic [ADDR_W-1:0] S0_PADDR,
  input  logic [DATA_W-1:0] S0_PWDATA,
  output logic [DATA_W-1:0] S0_PRDATA,
  output logic              S0_PREADY,
  output logic              S0_PSLVERR,
  input  logic              S1_PSEL,
  input  logic              S1_PENABLE,
  input  logic              S1_PWRITE,
  input  logic [ADDR_W-1:0] S1_PADDR,
  input  logic [DATA_W-1:0] S1_PWDATA,
  output logic [DATA_W-1:0] S1_PRDATA,
  output logic              S1_PREADY,
  output logic              S1_PSLVERR,
  output logic              M_PSEL,
  output logic              M_PENABLE,
  output logic              M_PWRITE,
  output logic [ADDR_W-1:0] M_PADDR,
  output logic [DATA_W-1:0] M_PWDATA,
  input  logic [DATA_W-1:0] M_PRDATA,
  input  logic              M_PREADY,
  input  logic              M_PSLVERR,
  output logic [1:0]        GRANT,
  output logic              BUSY,
  output logic              TIMEOUT_ERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [9:0]        wd_cnt;
  logic              last_s1;
  logic              pick_s1;
  logic              req_any;
  logic              wd_expired;
  logic              m_sel;
  logic              m_en;
  logic              done;
  logic [1:0]        grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              slverr_q;
  logic              tmo_q;
  logic              unused_penable;

  // Requests are recognised on PSEL alone; PENABLE carries no extra information here.
  assign unused_penable = S0_PENABLE ^ S1_PENABLE;

  always_ff @(posedge CLK_BASE) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pick_s1    = 1'b0;
    wd_expired = 1'b0;
    m_sel      = 1'b0;
    m_en       = 1'b0;
    done       = 1'b0;
    req_any    = S0_PSEL | S1_PSEL;
    case (state)
      IDLE: begin
        pick_s1 = (S0_PSEL && S1_PSEL) ? !last_s1 : S1_PSEL;
        if (req_any) state_next = SETUP;
      end
      SETUP: begin
        m_sel      = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        m_sel = 1'b1;
        m_en  = 1'b1;
        if (M_PREADY) begin
          state_next = DONE;
        end else if (wd_cnt == WD_LAST) begin
          wd_expired = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_BASE) begin
    if (!RESET_N) begin
      wd_cnt   <= '0;
      last_s1  <= 1'b1;
      grant_q  <= '0;
      addr_q   <= '0;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (state == ACCESS) wd_cnt <= wd_cnt + 10'd1;
      else                 wd_cnt <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_q  <= pick_s1 ? 2'b10 : 2'b01;
            addr_q   <= pick_s1 ? S1_PADDR  : S0_PADDR;
            pwrite_q <= pick_s1 ? S1_PWRITE : S0_PWRITE;
            wdata_q  <= pick_s1 ? S1_PWDATA : S0_PWDATA;
          end
        end
        ACCESS: begin
          if (M_PREADY) begin
            rdata_q  <= pwrite_q ? '0 : M_PRDATA;
            slverr_q <= M_PSLVERR;
          end else if (wd_expired) begin
            rdata_q  <= '0;
            slverr_q <= 1'b1;
            tmo_q    <= 1'b1;
          end
        end
        DONE: begin
          last_s1 <= grant_q[1];
          grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign M_PSEL      = m_sel;
  assign M_PENABLE   = m_en;
  assign M_PADDR     = addr_q;
  assign M_PWRITE    = pwrite_q;
  assign M_PWDATA    = wdata_q;
  assign GRANT       = grant_q;
  assign BUSY        = (state != IDLE);
  assign TIMEOUT_ERR = tmo_q;

  // Response fields are forced to zero outside the owner's single PREADY cycle.
  assign S0_PREADY  = done & grant_q[0];
  assign S1_PREADY  = done & grant_q[1];
  assign S0_PRDATA  = S0_PREADY ? rdata_q : '0;
  assign S1_PRDATA  = S1_PREADY ? rdata_q : '0;
  assign S0_PSLVERR = S0_PREADY & slverr_q;
  assign S1_PSLVERR = S1_PREADY & slverr_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Randomized bench for apb_mem_arbiter against a transaction-timeline reference model.
module tb_apb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int TMO  = 4;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_psel, s0_penable, s0_pwrite, s0_pready, s0_pslverr;
  logic [AW-1:0] s0_paddr;
  logic [DW-1:0] s0_pwdata, s0_prdata;
  logic          s1_psel, s1_penable, s1_pwrite, s1_pready, s1_pslverr;
  logic [AW-1:0] s1_paddr;
  logic [DW-1:0] s1_pwdata, s1_prdata;
  logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_prdata;
  logic [1:0]    grant;
  logic          busy, timeout_err;

  always #5 clk = ~clk;

  apb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK_BASE(clk), .RESET_N(rst_n),
    .S0_PSEL(s0_psel), .S0_PENABLE(s0_penable), .S0_PWRITE(s0_pwrite),
    .S0_PADDR(s0_paddr), .S0_PWDATA(s0_pwdata), .S0_PRDATA(s0_prdata),
    .S0_PREADY(s0_pready), .S0_PSLVERR(s0_pslverr),
    .S1_PSEL(s1_psel), .S1_PENABLE(s1_penable), .S1_PWRITE(s1_pwrite),
    .S1_PADDR(s1_paddr), .S1_PWDATA(s1_pwdata), .S1_PRDATA(s1_prdata),
    .S1_PREADY(s1_pready), .S1_PSLVERR(s1_pslverr),
    .M_PSEL(m_psel), .M_PENABLE(m_penable), .M_PWRITE(m_pwrite),
    .M_PADDR(m_paddr), .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata),
    .M_PREADY(m_pready), .M_PSLVERR(m_pslverr),
    .GRANT(grant), .BUSY(busy), .TIMEOUT_ERR(timeout_err)
  );

  // One transfer as a timeline: SETUP occupies cycle setup_at, ACCESS runs until done_at.
  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    int            setup_at;
    int            done_at;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } xfer_t;

  xfer_t         cur;
  bit            have_xfer;
  bit            in_rst;
  int            last_port;
  bit            pend [2];
  bit            fresh [2];
  logic [AW-1:0] req_addr [2];
  logic          req_wr [2];
  logic [DW-1:0] req_wdata [2];
  int            cyc;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    int w;
    cyc++;
    in_rst = !rst_n;
    if (!rst_n) begin
      have_xfer = 1'b0;
      last_port = 1;
    end else if (!have_xfer) begin
      if (s0_psel || s1_psel) begin
        if (s0_psel && s1_psel) w = 1 - last_port;
        else                    w = s0_psel ? 0 : 1;
        cur.port     = w;
        cur.addr     = req_addr[w];
        cur.wr       = req_wr[w];
        cur.wdata    = req_wdata[w];
        cur.setup_at = cyc;
        cur.done_at  = -1;
        cur.rdata    = '0;
        cur.err      = 1'b0;
        cur.tmo      = 1'b0;
        have_xfer    = 1'b1;
      end
    end else if (cur.done_at < 0) begin
      if (cyc - 1 > cur.setup_at) begin
        if (m_pready) begin
          cur.done_at = cyc;
          cur.rdata   = cur.wr ? '0 : m_prdata;
          cur.err     = m_pslverr;
        end else if (cyc - 1 - cur.setup_at == TMO) begin
          cur.done_at = cyc;
          cur.rdata   = '0;
          cur.err     = 1'b1;
          cur.tmo     = 1'b1;
        end
      end
    end else begin
      last_port      = cur.port;
      pend[cur.port] = 1'b0;
      have_xfer      = 1'b0;
    end
  endtask

  task automatic drive_next(input int i);
    bit directed;
    bit own0;
    bit own1;
    directed = (i < 40);
    rst_n = !((i < 2) || (!directed && $urandom_range(99) < 2));
    for (int p = 0; p < 2; p++) begin
      fresh[p] = 1'b0;
      if (!pend[p] && (directed || $urandom_range(99) < 35)) begin
        pend[p]      = 1'b1;
        fresh[p]     = 1'b1;
        req_addr[p]  = AW'($urandom);
        req_wr[p]    = 1'($urandom_range(1));
        req_wdata[p] = $urandom;
      end
    end
    // The owner's bus is scrambled while its transfer is in flight; only the latch may matter.
    own0 = have_xfer && cur.port == 0;
    own1 = have_xfer && cur.port == 1;
    s0_psel    = own0 ? 1'($urandom_range(1)) : pend[0];
    s0_penable = s0_psel & !fresh[0];
    s0_paddr   = own0 ? AW'($urandom) : req_addr[0];
    s0_pwrite  = own0 ? 1'($urandom_range(1)) : req_wr[0];
    s0_pwdata  = own0 ? $urandom : req_wdata[0];
    s1_psel    = own1 ? 1'($urandom_range(1)) : pend[1];
    s1_penable = s1_psel & !fresh[1];
    s1_paddr   = own1 ? AW'($urandom) : req_addr[1];
    s1_pwrite  = own1 ? 1'($urandom_range(1)) : req_wr[1];
    s1_pwdata  = own1 ? $urandom : req_wdata[1];
    m_pready   = directed ? 1'b1 : ($urandom_range(2) == 0);
    m_prdata   = $urandom;
    m_pslverr  = ($urandom_range(3) == 0);
  endtask

  task automatic check_outputs();
    bit done_now;
    bit sel_e;
    bit rdy0;
    bit rdy1;
    done_now = have_xfer && cur.done_at == cyc;
    sel_e    = have_xfer && !done_now;
    rdy0     = done_now && cur.port == 0;
    rdy1     = done_now && cur.port == 1;
    chk("grant", 64'(grant), have_xfer ? (cur.port == 1 ? 64'd2 : 64'd1) : 64'd0);
    chk("busy", 64'(busy), 64'(have_xfer));
    chk("m_psel", 64'(m_psel), 64'(sel_e));
    chk("m_penable", 64'(m_penable), 64'(sel_e && cyc > cur.setup_at));
    if (sel_e) begin
      chk("m_paddr", 64'(m_paddr), 64'(cur.addr));
      chk("m_pwrite", 64'(m_pwrite), 64'(cur.wr));
      chk("m_pwdata", 64'(m_pwdata), 64'(cur.wdata));
    end
    if (in_rst) begin
      chk("rst_paddr", 64'(m_paddr), 64'd0);
      chk("rst_pwrite", 64'(m_pwrite), 64'd0);
      chk("rst_pwdata", 64'(m_pwdata), 64'd0);
    end
    chk("s0_pready", 64'(s0_pready), 64'(rdy0));
    chk("s0_prdata", 64'(s0_prdata), rdy0 ? 64'(cur.rdata) : 64'd0);
    chk("s0_pslverr", 64'(s0_pslverr), 64'(rdy0 && cur.err));
    chk("s1_pready", 64'(s1_pready), 64'(rdy1));
    chk("s1_prdata", 64'(s1_prdata), rdy1 ? 64'(cur.rdata) : 64'd0);
    chk("s1_pslverr", 64'(s1_pslverr), 64'(rdy1 && cur.err));
    chk("timeout_err", 64'(timeout_err), 64'(done_now && cur.tmo));
  endtask

  initial begin
    cyc       = 0;
    n_vec     = 0;
    n_err     = 0;
    have_xfer = 1'b0;
    in_rst    = 1'b0;
    last_port = 1;
    for (int p = 0; p < 2; p++) begin
      pend[p]      = 1'b0;
      fresh[p]     = 1'b0;
      req_addr[p]  = '0;
      req_wr[p]    = 1'b0;
      req_wdata[p] = '0;
    end
    rst_n      = 1'b0;
    s0_psel    = 1'b0; s0_penable = 1'b0; s0_pwrite = 1'b0; s0_paddr = '0; s0_pwdata = '0;
    s1_psel    = 1'b0; s1_penable = 1'b0; s1_pwrite = 1'b0; s1_paddr = '0; s1_pwdata = '0;
    m_pready   = 1'b0; m_pslverr = 1'b0; m_prdata = '0;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      model_step();
      #1;
      drive_next(i);
      @(negedge clk);
      check_outputs();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
